stream_checker: RTL

- Self-checking token sink for the downstream end of a dataflow graph output port (`dout_req_N` / `dout_ack_N` / `dout_N`).
- Acts as the requesting side of the req/ack token protocol. It raises `req`, captures one token per `ack` pulse and compares each token against an affine reference sequence.
- Reports the token count, error statistics, completion and a stall watchdog, so benches can flag a wrong result or a hang without a VCD.
- Replaces the plain consumer in generated benches where the graph's transfer function is affine in the input index.

---
 rtl/stream_checker.sv | 131 +++++++++++++
 1 files changed

// File: rtl/stream_checker.sv
// Self-checking req/ack token sink: requests tokens, compares each one against the
// affine sequence scale*(initial_value+k)+offset, and reports errors, completion and stalls.
module stream_checker #(
    parameter int data_width     = 32,
    parameter int scale          = 3,
    parameter int offset         = 2,
    parameter int initial_value  = 0,
    parameter int max_data_size  = 5000,
    parameter int timeout_cycles = 1024,
    parameter int gap_cycles     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  req,
    input  logic                  ack,
    input  logic [data_width-1:0] din,
    output logic [31:0]           count,
    output logic [15:0]           err_count,
    output logic [31:0]           first_err_index,
    output logic [data_width-1:0] first_err_data,
    output logic                  done,
    output logic                  timeout
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_HOLD,
        ST_GAP,
        ST_DONE,
        ST_TIMEOUT
    } state_t;

    localparam logic [data_width-1:0] exp_init = data_width'(scale * initial_value + offset);
    localparam logic [data_width-1:0] scale_w  = data_width'(scale);
    localparam logic [31:0]           max_w    = 32'(max_data_size);
    localparam logic [31:0]           tmo_w    = 32'(timeout_cycles);
    localparam logic [31:0]           gap_last = 32'(gap_cycles - 1);

    state_t                state;
    logic                  ack_d;
    logic [data_width-1:0] exp_val;
    logic [31:0]           wdog;
    logic [31:0]           gap_cnt;
    logic                  accept;

    // Only a fresh 0->1 edge of ack while requesting is a new token.
    assign accept = (state == ST_REQ) && ack && !ack_d;

    // NOTE: all state below is updated with <= so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            req             <= 1'b0;
            ack_d           <= 1'b0;
            exp_val         <= exp_init;
            wdog            <= '0;
            gap_cnt         <= '0;
            count           <= '0;
            err_count       <= '0;
            first_err_index <= '0;
            first_err_data  <= '0;
            done            <= 1'b0;
            timeout         <= 1'b0;
        end else begin
            ack_d <= ack;
            case (state)
                ST_IDLE: begin
                    req   <= 1'b1;
                    wdog  <= '0;
                    state <= ST_REQ;
                end
                ST_REQ: begin
                    if (accept) begin
                        count   <= count + 32'd1;
                        exp_val <= exp_val + scale_w;
                        wdog    <= '0;
                        req     <= 1'b0;
                        state   <= ST_HOLD;
                        if (din != exp_val) begin
                            if (err_count != 16'hFFFF) begin
                                err_count <= err_count + 16'd1;
                            end
                            if (err_count == 16'd0) begin
                                first_err_index <= count;
                                first_err_data  <= din;
                            end
                        end
                    end else if (wdog + 32'd1 == tmo_w) begin
                        wdog    <= wdog + 32'd1;
                        req     <= 1'b0;
                        timeout <= 1'b1;
                        state   <= ST_TIMEOUT;
                    end else begin
                        wdog <= wdog + 32'd1;
                    end
                end
                ST_HOLD: begin
                    if (!ack) begin
                        if (count == max_w) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else if (gap_cycles > 0) begin
                            gap_cnt <= '0;
                            state   <= ST_GAP;
                        end else begin
                            req   <= 1'b1;
                            state <= ST_REQ;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == gap_last) begin
                        req   <= 1'b1;
                        state <= ST_REQ;
                    end else begin
                        gap_cnt <= gap_cnt + 32'd1;
                    end
                end
                ST_DONE, ST_TIMEOUT: begin
                    req <= 1'b0;
                end
                default: begin
                    req   <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
